regfile_sb: RTL and testbench

- Parametrised successor of the 32x32 CPU register file: a DEPTH x DATA_W register file with two asynchronous read ports and one write port.
- Adds a per-register busy scoreboard. Issue marks a destination pending; writeback clears it. Read ports report operand-pending so the decode stage can stall.
- Sits between decode/issue and writeback in the MIPS core.
- The ov input suppresses the register write on arithmetic overflow.

---
 rtl/regfile_sb.sv | 94 +++++++++
 tb/tb_regfile_sb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// DATA_W x 2**ADDR_W register file, two combinational read ports, one write port, per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle committing write onto the read ports.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              ov,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic ov_sup, commit, busy_clr, busy_set;
  logic wz, iz, r1z, r2z;

  always_comb begin
    wz  = (ZERO_REG != 0) && (waddr == '0);
    iz  = (ZERO_REG != 0) && (iss_addr == '0);
    r1z = (ZERO_REG != 0) && (raddr1 == '0);
    r2z = (ZERO_REG != 0) && (raddr2 == '0);
    // Only a clean 1 on ov suppresses; X/Z let the write through.
    ov_sup   = (ov === 1'b1);
    commit   = we && !ov_sup && !wz;
    busy_clr = we && !wz;
    busy_set = iss_valid && !iz;
  end

  always_comb begin
    regs_d = regs_q;
    if (commit) regs_d[waddr] = wdata;
  end

  // Set is applied after clear so a same-cycle issue supersedes the writeback.
  always_comb begin
    busy_d = busy_q;
    if (busy_clr) busy_d[waddr]    = 1'b0;
    if (busy_set) busy_d[iss_addr] = 1'b1;
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_comb begin
    rdata1 = r1z ? '0 : regs_q[raddr1];
    rdata2 = r2z ? '0 : regs_q[raddr2];
    busy1  = r1z ? 1'b0 : busy_q[raddr1];
    busy2  = r2z ? 1'b0 : busy_q[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (commit && (waddr == raddr1)) begin
      rdata1 = wdata;
      busy1  = busy_set && (iss_addr == raddr1);
    end
    if (commit && (waddr == raddr2)) begin
      rdata2 = wdata;
      busy2  = busy_set && (iss_addr == raddr2);
    end
`endif
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb: default build instance plus a 16x8, ZERO_REG=0 instance.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        we, ov, iss_valid;
  logic [4:0]  waddr, iss_addr, raddr1, raddr2;
  logic [31:0] wdata, rdata1, rdata2;
  logic        busy1, busy2;
  logic [5:0]  busy_cnt;

  regfile_sb u_dut (
    .clk(clk), .rst(rst), .we(we), .ov(ov), .waddr(waddr), .wdata(wdata),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
  );

  logic        we2, ov2, iss_valid2;
  logic [2:0]  waddr2, iss_addr2, raddr1_2, raddr2_2;
  logic [15:0] wdata2, rdata1_2, rdata2_2;
  logic        busy1_2, busy2_2;
  logic [3:0]  busy_cnt2;

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_dut2 (
    .clk(clk), .rst(rst), .we(we2), .ov(ov2), .waddr(waddr2), .wdata(wdata2),
    .iss_valid(iss_valid2), .iss_addr(iss_addr2), .raddr1(raddr1_2), .raddr2(raddr2_2),
    .rdata1(rdata1_2), .rdata2(rdata2_2), .busy1(busy1_2), .busy2(busy2_2), .busy_cnt(busy_cnt2)
  );

  typedef struct {
    logic        we, ov;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss;
    logic [4:0]  iaddr, ra1, ra2;
    logic [31:0] e_rd1, e_rd2;
    logic        e_b1, e_b2;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs [13];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(logic w, logic o, logic [4:0] wa, logic [31:0] wd, logic is,
                              logic [4:0] ia, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] r1, logic [31:0] r2, logic b1, logic b2, logic [5:0] c);
    vec_t v;
    v.we = w; v.ov = o; v.waddr = wa; v.wdata = wd; v.iss = is; v.iaddr = ia;
    v.ra1 = a1; v.ra2 = a2; v.e_rd1 = r1; v.e_rd2 = r2; v.e_b1 = b1; v.e_b2 = b2; v.e_cnt = c;
    return v;
  endfunction

  function automatic logic [15:0] pat(int i);
    return 16'hA5A5 ^ (16'h1111 * 16'(i));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; ov = 0; waddr = 0; wdata = 0; iss_valid = 0; iss_addr = 0;
  endtask

  initial begin
    idle();
    raddr1 = 0; raddr2 = 0;
    we2 = 0; ov2 = 0; waddr2 = 0; wdata2 = 0; iss_valid2 = 0; iss_addr2 = 0;
    raddr1_2 = 0; raddr2_2 = 0;

    vecs[0]  = mk(1,0,7,32'h12345678,0,0, 7,0, BYP ? 32'h12345678 : 32'h0, 0, 0,0,0);
    vecs[1]  = mk(1,0,0,32'hFFFFFFFF,0,0, 0,7, 0, 32'h12345678, 0,0,0);
    vecs[2]  = mk(0,0,0,0,           1,0, 0,7, 0, 32'h12345678, 0,0,0);
    vecs[3]  = mk(1,0,3,32'h1,       0,0, 0,3, 0, BYP ? 32'h1 : 32'h0, 0,0,0);
    vecs[4]  = mk(0,0,0,0,           1,3, 3,0, 32'h1, 0, 0,0,0);
    vecs[5]  = mk(1,1,3,32'h55,      0,0, 3,0, 32'h1, 0, 1,0,1);
    vecs[6]  = mk(0,0,0,0,           0,0, 3,0, 32'h1, 0, 0,0,0);
    vecs[7]  = mk(0,0,0,0,           1,4, 4,9, 0, 0, 0,0,0);
    vecs[8]  = mk(0,0,0,0,           1,9, 4,9, 0, 0, 1,0,1);
    vecs[9]  = mk(0,0,0,0,           1,4, 4,9, 0, 0, 1,1,2);
    vecs[10] = mk(1,0,4,32'h44,      1,4, 4,9, BYP ? 32'h44 : 32'h0, 0, 1,1,2);
    vecs[11] = mk(1,0,9,32'h99,      0,0, 4,9, 32'h44, BYP ? 32'h99 : 32'h0, 1, BYP ? 1'b0 : 1'b1, 2);
    vecs[12] = mk(0,0,0,0,           0,0, 4,9, 32'h44, 32'h99, 1,0,1);

    #2;
    raddr1 = 5; raddr2 = 7;
    #1;
    check("rst_rdata1", rdata1, 0);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_cnt", 32'(busy_cnt), 0);
    step();
    rst = 0;
    step();

    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; ov = vecs[i].ov; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      iss_valid = vecs[i].iss; iss_addr = vecs[i].iaddr;
      raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
      #2;
      check($sformatf("v%0d_rdata1", i), rdata1, vecs[i].e_rd1);
      check($sformatf("v%0d_rdata2", i), rdata2, vecs[i].e_rd2);
      check($sformatf("v%0d_busy1", i), 32'(busy1), 32'(vecs[i].e_b1));
      check($sformatf("v%0d_busy2", i), 32'(busy2), 32'(vecs[i].e_b2));
      check($sformatf("v%0d_cnt", i), 32'(busy_cnt), 32'(vecs[i].e_cnt));
      step();
    end
    idle();

    // ov floating must not block the write
    we = 1; ov = 1'bz; waddr = 3; wdata = 32'h66;
    step();
    idle();
    raddr1 = 3;
    #1;
    check("ovz_rdata1", rdata1, 32'h66);

    // same-cycle read of a committing write to a busy register
    we = 1; waddr = 10; wdata = 32'h11;
    step();
    idle();
    iss_valid = 1; iss_addr = 10;
    step();
    idle();
    we = 1; waddr = 10; wdata = 32'hA5A5A5A5; raddr1 = 10;
    #2;
    check("byp_rdata1", rdata1, BYP ? 32'hA5A5A5A5 : 32'h11);
    check("byp_busy1", 32'(busy1), BYP ? 32'd0 : 32'd1);
    step();
    idle();
    #1;
    check("byp_next_rdata1", rdata1, 32'hA5A5A5A5);
    check("byp_next_busy1", 32'(busy1), 0);
    check("byp_next_cnt", 32'(busy_cnt), 1);

    // asynchronous reset in the middle of a cycle
    we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    step();
    idle();
    iss_valid = 1; iss_addr = 6;
    step();
    idle();
    raddr1 = 5; raddr2 = 4;
    #2;
    check("pre_rst_rdata1", rdata1, 32'hDEADBEEF);
    check("pre_rst_cnt", 32'(busy_cnt), 2);
    rst = 1;
    #1;
    check("mid_rst_rdata1", rdata1, 0);
    check("mid_rst_cnt", 32'(busy_cnt), 0);
    check("mid_rst_busy2", 32'(busy2), 0);
    step();
    rst = 0;
    step();

    // 16-bit, 8-entry instance with an ordinary register 0
    for (int i = 0; i < 8; i++) begin
      we2 = 1; waddr2 = 3'(i); wdata2 = pat(i);
      step();
    end
    we2 = 0;
    for (int i = 0; i < 8; i++) begin
      raddr1_2 = 3'(i); raddr2_2 = 3'(7 - i);
      #1;
      check($sformatf("p_rdata1_r%0d", i), 32'(rdata1_2), 32'(pat(i)));
      check($sformatf("p_rdata2_r%0d", 7 - i), 32'(rdata2_2), 32'(pat(7 - i)));
    end
    step();
    for (int i = 0; i < 8; i++) begin
      iss_valid2 = 1; iss_addr2 = 3'(i);
      step();
    end
    iss_valid2 = 0;
    raddr1_2 = 0; raddr2_2 = 7;
    #1;
    check("p_cnt_all", 32'(busy_cnt2), 8);
    check("p_busy1_r0", 32'(busy1_2), 1);
    check("p_busy2_r7", 32'(busy2_2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
